cache_stress_checker: RTL and testbench

CACHE_STRESS_CHECKER -- requirements
Module: cache_stress_checker

---
 rtl/cache_stress_checker.sv | 195 +++++++++++++++++++
 tb/tb_cache_stress_checker.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/cache_stress_checker.sv
// Memory stress checker: clears a memory-under-test and a shadow copy, hammers both with
// xorshift128 write traffic, and counts readback and shadow mismatches.
//
// state | meaning
// IDLE  | waiting for start after reset
// INIT  | zeroing both arrays, one address per cycle
// RUN   | PRNG-driven writes with readback/shadow checks
// DRAIN | completing the check issued in the last RUN cycle
// DONE  | results held until the next start
module cache_stress_checker #(
   parameter int unsigned ADDR_BITS   = 5,
   parameter int unsigned DATA_BITS   = 16,
   parameter int unsigned TEST_CYCLES = 32'd16777216,
   parameter logic [31:0] SEED        = 32'd1481231,
   parameter int unsigned ERR_BITS    = 16
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 start,
   input  logic [1:0]           mode,
   input  logic                 inject_fault,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [ERR_BITS-1:0]  error_count,
   output logic [ADDR_BITS-1:0] first_err_addr,
   output logic [DATA_BITS-1:0] first_err_exp,
   output logic [DATA_BITS-1:0] first_err_got
);

   localparam int unsigned        DEPTH     = 1 << ADDR_BITS;
   localparam logic [31:0]        INIT_LOAD = 32'(DEPTH - 1);
   localparam logic [31:0]        RUN_LOAD  = 32'(TEST_CYCLES - 1);
   localparam logic [ERR_BITS-1:0] ERR_MAX  = '1;
   localparam logic [DATA_BITS-1:0] BIT0    = DATA_BITS'(1);
   localparam logic [31:0]        X0_INIT   = 32'd12345678;
   localparam logic [31:0]        X1_INIT   = 32'd36243669;
   localparam logic [31:0]        X2_INIT   = 32'd521288629;

   typedef enum logic [2:0] {S_IDLE, S_INIT, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t                 state;
   logic [1:0]             mode_q;
   logic [31:0]            cnt;
   logic [ADDR_BITS-1:0]   ptr;
   logic [31:0]            x0, x1, x2, x3;
   logic [31:0]            t_a, t_b, rnd;

   logic [DATA_BITS-1:0]   mem_mut [DEPTH];
   logic [DATA_BITS-1:0]   mem_shd [DEPTH];

   logic                   rb_v;
   logic [ADDR_BITS-1:0]   rb_addr;
   logic [DATA_BITS-1:0]   rb_data;
   logic                   sh_v;
   logic [ADDR_BITS-1:0]   sh_addr;
   logic [DATA_BITS-1:0]   sh_mut;
   logic [DATA_BITS-1:0]   sh_shd;

   logic [ADDR_BITS-1:0]   wr_addr;
   logic [DATA_BITS-1:0]   wr_data;
   logic [ADDR_BITS-1:0]   rd_addr;
   logic [DATA_BITS-1:0]   rb_got;
   logic                   rb_fail;
   logic                   sh_fail;
   logic [ERR_BITS:0]      err_sum;
   logic [ERR_BITS-1:0]    err_next;

   always_comb begin
      t_a      = x3 ^ (x3 << 11);
      t_b      = t_a ^ (t_a >> 8);
      rnd      = t_b ^ x0 ^ (x0 >> 19);
      wr_addr  = (mode_q == 2'd1) ? ptr : rnd[ADDR_BITS-1:0];
      wr_data  = rnd[DATA_BITS-1:0];
      rd_addr  = rnd[31 -: ADDR_BITS];
      rb_got   = mem_mut[rb_addr];
      rb_fail  = rb_v && (rb_got != rb_data);
      sh_fail  = sh_v && (sh_mut != sh_shd);
      // One spare carry bit: any carry out means the counter has hit its ceiling.
      err_sum  = {1'b0, error_count} + {{ERR_BITS{1'b0}}, rb_fail} + {{ERR_BITS{1'b0}}, sh_fail};
      err_next = err_sum[ERR_BITS] ? ERR_MAX : err_sum[ERR_BITS-1:0];
   end

   // Arrays carry no reset; INIT zeroes them before every test.
   always_ff @(posedge clock) begin
      if (!reset) begin
         if (state == S_INIT) begin
            mem_mut[ptr] <= '0;
            mem_shd[ptr] <= '0;
         end else if (state == S_RUN) begin
            mem_mut[wr_addr] <= wr_data ^ (inject_fault ? BIT0 : '0);
            mem_shd[wr_addr] <= wr_data;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state          <= S_IDLE;
         busy           <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
         error_count    <= '0;
         first_err_addr <= '0;
         first_err_exp  <= '0;
         first_err_got  <= '0;
         mode_q         <= 2'd0;
         cnt            <= '0;
         ptr            <= '0;
         x0             <= X0_INIT;
         x1             <= X1_INIT;
         x2             <= X2_INIT;
         x3             <= SEED;
         rb_v           <= 1'b0;
         rb_addr        <= '0;
         rb_data        <= '0;
         sh_v           <= 1'b0;
         sh_addr        <= '0;
         sh_mut         <= '0;
         sh_shd         <= '0;
      end else begin
         rb_v        <= 1'b0;
         sh_v        <= 1'b0;
         error_count <= err_next;
         if ((rb_fail || sh_fail) && (error_count == '0)) begin
            if (rb_fail) begin
               first_err_addr <= rb_addr;
               first_err_exp  <= rb_data;
               first_err_got  <= rb_got;
            end else begin
               first_err_addr <= sh_addr;
               first_err_exp  <= sh_shd;
               first_err_got  <= sh_mut;
            end
         end
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state          <= S_INIT;
                  busy           <= 1'b1;
                  done           <= 1'b0;
                  pass           <= 1'b0;
                  mode_q         <= (mode == 2'd3) ? 2'd0 : mode;
                  cnt            <= INIT_LOAD;
                  ptr            <= '0;
                  x0             <= X0_INIT;
                  x1             <= X1_INIT;
                  x2             <= X2_INIT;
                  x3             <= SEED;
                  error_count    <= '0;
                  first_err_addr <= '0;
                  first_err_exp  <= '0;
                  first_err_got  <= '0;
               end
            end
            S_INIT: begin
               ptr <= ptr + 1'b1;
               if (cnt == '0) begin
                  state <= S_RUN;
                  cnt   <= RUN_LOAD;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            S_RUN: begin
               x0      <= rnd;
               x1      <= x0;
               x2      <= x1;
               x3      <= x2;
               ptr     <= ptr + 1'b1;
               rb_v    <= 1'b1;
               rb_addr <= wr_addr;
               rb_data <= wr_data;
               sh_v    <= (mode_q == 2'd2);
               sh_addr <= rd_addr;
               sh_mut  <= mem_mut[rd_addr];
               sh_shd  <= mem_shd[rd_addr];
               if (cnt == '0) begin
                  state <= S_DRAIN;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            S_DRAIN: begin
               state <= S_DONE;
               busy  <= 1'b0;
               done  <= 1'b1;
               pass  <= (err_next == '0);
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cache_stress_checker.sv
// Bench for cache_stress_checker: two instances (16-bit and 4-bit error counters) driven
// identically and compared against a sequential reference of one whole test.
module tb_cache_stress_checker;
   localparam int AB = 5;
   localparam int DB = 16;
   localparam int TC = 64;
   localparam int N  = 1 << AB;
   localparam int LAT = N + TC + 1;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic start = 1'b0;
   logic [1:0] mode = 2'd0;
   logic inject_fault = 1'b0;

   logic busy_a, done_a, pass_a;
   logic [15:0] err_a;
   logic [AB-1:0] faddr_a;
   logic [DB-1:0] fexp_a, fgot_a;
   logic busy_b, done_b, pass_b;
   logic [3:0] err_b;
   logic [AB-1:0] faddr_b;
   logic [DB-1:0] fexp_b, fgot_b;

   cache_stress_checker #(.ADDR_BITS(AB), .DATA_BITS(DB), .TEST_CYCLES(TC), .ERR_BITS(16)) dut_a (
      .clock(clock), .reset(reset), .start(start), .mode(mode), .inject_fault(inject_fault),
      .busy(busy_a), .done(done_a), .pass(pass_a), .error_count(err_a),
      .first_err_addr(faddr_a), .first_err_exp(fexp_a), .first_err_got(fgot_a));

   cache_stress_checker #(.ADDR_BITS(AB), .DATA_BITS(DB), .TEST_CYCLES(TC), .ERR_BITS(4)) dut_b (
      .clock(clock), .reset(reset), .start(start), .mode(mode), .inject_fault(inject_fault),
      .busy(busy_b), .done(done_b), .pass(pass_b), .error_count(err_b),
      .first_err_addr(faddr_b), .first_err_exp(fexp_b), .first_err_got(fgot_b));

   always #5 clock = ~clock;

   int vectors = 0;
   int miscompares = 0;
   logic [63:0] fault_mask;
   int m_cnt;
   logic [31:0] m_addr, m_exp, m_got;
   int done_at_a, done_at_b, busy_cnt;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Whole-test reference: walk the write stream once, apply each write to two plain
   // arrays and judge every check the moment its data is known.
   task automatic run_model(input int md);
      logic [31:0] x0, x1, x2, x3, t, r;
      logic [15:0] mutm [N];
      logic [15:0] shdm [N];
      logic [15:0] d, sm, ss;
      int wa, ra;
      bit rbf, shf;
      x0 = 32'd12345678; x1 = 32'd36243669; x2 = 32'd521288629; x3 = 32'd1481231;
      for (int i = 0; i < N; i++) begin
         mutm[i] = '0;
         shdm[i] = '0;
      end
      m_cnt = 0; m_addr = '0; m_exp = '0; m_got = '0;
      for (int k = 0; k < TC; k++) begin
         t = x3 ^ (x3 << 11);
         t = t ^ (t >> 8);
         r = t ^ x0 ^ (x0 >> 19);
         x3 = x2; x2 = x1; x1 = x0; x0 = r;
         wa = (md == 1) ? (k % N) : int'(r % N);
         ra = int'(r >> (32 - AB));
         d  = r[15:0];
         sm = mutm[ra];
         ss = shdm[ra];
         mutm[wa] = d ^ {15'd0, fault_mask[k]};
         shdm[wa] = d;
         rbf = (mutm[wa] != d);
         shf = (md == 2) && (sm != ss);
         if (m_cnt == 0) begin
            if (rbf) begin
               m_addr = 32'(wa); m_exp = {16'd0, d}; m_got = {16'd0, mutm[wa]};
            end else if (shf) begin
               m_addr = 32'(ra); m_exp = {16'd0, ss}; m_got = {16'd0, sm};
            end
         end
         m_cnt += int'(rbf) + int'(shf);
      end
   endtask

   task automatic do_run(input logic [1:0] md, input bit poke_start, input string tag);
      run_model((md == 2'd3) ? 0 : int'(md));
      @(negedge clock);
      start = 1'b1; mode = md; inject_fault = 1'b0;
      busy_cnt = 0; done_at_a = -1; done_at_b = -1;
      for (int c = 0; c < 300; c++) begin
         @(negedge clock);
         start = poke_start && (c == N + 5);
         if (start) mode = ~md;
         if (done_a && done_at_a < 0) done_at_a = c;
         if (done_b && done_at_b < 0) done_at_b = c;
         if (busy_a) busy_cnt++;
         inject_fault = (c >= N && c < N + TC) ? fault_mask[c - N] : 1'b0;
         if (done_at_a >= 0 && done_at_b >= 0) break;
      end
      start = 1'b0; inject_fault = 1'b0;
      check({tag, " done_lat_a"}, 32'(done_at_a), 32'(LAT));
      check({tag, " done_lat_b"}, 32'(done_at_b), 32'(LAT));
      check({tag, " busy_cycles"}, 32'(busy_cnt), 32'(LAT));
      check({tag, " err_a"}, 32'(err_a), (m_cnt > 65535) ? 32'd65535 : 32'(m_cnt));
      check({tag, " err_b"}, 32'(err_b), (m_cnt > 15) ? 32'd15 : 32'(m_cnt));
      check({tag, " pass_a"}, 32'(pass_a), 32'(m_cnt == 0));
      check({tag, " pass_b"}, 32'(pass_b), 32'(m_cnt == 0));
      check({tag, " faddr_a"}, 32'(faddr_a), m_addr);
      check({tag, " fexp_a"}, 32'(fexp_a), m_exp);
      check({tag, " fgot_a"}, 32'(fgot_a), m_got);
      check({tag, " faddr_b"}, 32'(faddr_b), m_addr);
      check({tag, " fgot_b"}, 32'(fgot_b), m_got);
   endtask

   task automatic abort_run(input int run_cycle, input string tag);
      @(negedge clock);
      start = 1'b1; mode = 2'd0;
      for (int c = 0; c <= N + run_cycle; c++) begin
         @(negedge clock);
         start = 1'b0;
      end
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      check({tag, " busy"}, 32'(busy_a), 32'd0);
      check({tag, " done"}, 32'(done_a), 32'd0);
      check({tag, " err"}, 32'(err_a), 32'd0);
   endtask

   initial begin
      int k;
      logic [1:0] md;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      repeat (5) @(negedge clock);
      check("idle busy", 32'(busy_a), 32'd0);
      check("idle done", 32'(done_a), 32'd0);
      check("idle pass", 32'(pass_a), 32'd0);
      check("idle err_a", 32'(err_a), 32'd0);
      check("idle err_b", 32'(err_b), 32'd0);

      fault_mask = '0;
      do_run(2'd0, 1'b0, "m0_clean");
      do_run(2'd1, 1'b0, "m1_clean");
      fault_mask = 64'd1 << 40;
      do_run(2'd1, 1'b0, "m1_order");
      check("m1_order addr", 32'(faddr_a), 32'd8);
      fault_mask = '0;
      do_run(2'd2, 1'b0, "m2_clean");
      fault_mask = 64'd1 << 10;
      do_run(2'd0, 1'b0, "m0_fault10");
      check("m0_fault10 got^exp", 32'(fgot_a ^ fexp_a), 32'd1);
      fault_mask = '1;
      do_run(2'd0, 1'b0, "all_fault");
      check("all_fault sat_b", 32'(err_b), 32'd15);
      fault_mask = 64'd1 << 3;
      do_run(2'd1, 1'b1, "start_ignored");

      for (int i = 0; i < 4; i++) begin
         fault_mask = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
         md = 2'($urandom_range(0, 3));
         do_run(md, 1'b0, $sformatf("rand%0d_m%0d", i, md));
      end

      abort_run(20, "abort1");
      fault_mask = '0;
      do_run(2'd0, 1'b0, "restart_clean");
      abort_run(20, "abort2");
      k = $urandom_range(0, TC - 1);
      fault_mask = 64'd1 << k;
      do_run(2'd0, 1'b0, "restart_fault");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
